// File: rtl/axi4_ram_responder.sv
// AXI4 slave backed by an on-chip word array; one outstanding burst per direction.
// Optional byte strobes: define AXI4_RAM_RESPONDER_WSTRB_EN.
module axi4_ram_responder #(
  parameter int DSIZE  = 32,
  parameter int ASIZE  = 32,
  parameter int IDSIZE = 4,
  parameter int DEPTH  = 1024,
  parameter logic [ASIZE-1:0] BASE_ADDR = '0
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [IDSIZE-1:0]   awid,
  input  logic [ASIZE-1:0]    awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DSIZE-1:0]    wdata,
  input  logic [DSIZE/8-1:0]  wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [IDSIZE-1:0]   bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [IDSIZE-1:0]   arid,
  input  logic [ASIZE-1:0]    araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [IDSIZE-1:0]   rid,
  output logic [DSIZE-1:0]    rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int SB = DSIZE / 8;
  localparam int SH = $clog2(SB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DSIZE-1:0] mem [DEPTH];

  function automatic logic [ASIZE-1:0] word_idx(
    input logic [ASIZE-1:0] a
  );
    return (a - BASE_ADDR) >> SH;
  endfunction

  // Whole burst is flagged if its last beat (or its start) falls outside
  function automatic logic oob(
    input logic [ASIZE-1:0] a,
    input logic [7:0]       len,
    input logic [1:0]       burst
  );
    logic [ASIZE:0] last;
    last = {1'b0, word_idx(a)}
         + ((burst == FIXED) ? '0 : {{(ASIZE-7){1'b0}}, len});
    return (a < BASE_ADDR) || (last >= (ASIZE+1)'(DEPTH));
  endfunction

  wstate_t           wst_q, wst_d;
  logic [IDSIZE-1:0] wid_q, wid_d;
  logic [ASIZE-1:0]  widx_q, widx_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              wfix_q, wfix_d;
  logic              wbad_q, wbad_d;
  logic              mem_we;

  always_comb begin
    wst_d  = wst_q;
    wid_d  = wid_q;
    widx_d = widx_q;
    wlen_d = wlen_q;
    wcnt_d = wcnt_q;
    wfix_d = wfix_q;
    wbad_d = wbad_q;
    mem_we = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        if (awvalid) begin
          wid_d  = awid;
          widx_d = word_idx(awaddr);
          wlen_d = awlen;
          wcnt_d = 8'd0;
          wfix_d = (awburst == FIXED);
          wbad_d = oob(awaddr, awlen, awburst);
          wst_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we = !wbad_q;
          wcnt_d = wcnt_q + 8'd1;
          if (!wfix_q) widx_d = widx_q + 1'b1;
          if (wlast || wcnt_q == wlen_q) wst_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wst_q  <= W_IDLE;
      wid_q  <= '0;
      widx_q <= '0;
      wlen_q <= '0;
      wcnt_q <= '0;
      wfix_q <= 1'b0;
      wbad_q <= 1'b0;
    end else begin
      wst_q  <= wst_d;
      wid_q  <= wid_d;
      widx_q <= widx_d;
      wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;
      wfix_q <= wfix_d;
      wbad_q <= wbad_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
`ifdef AXI4_RAM_RESPONDER_WSTRB_EN
      for (int b = 0; b < SB; b++) begin
        if (wstrb[b]) mem[widx_q[IW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
`else
      mem[widx_q[IW-1:0]] <= wdata;
`endif
    end
  end

  assign awready = (wst_q == W_IDLE);
  assign wready  = (wst_q == W_DATA);
  assign bvalid  = (wst_q == W_RESP);
  assign bid     = wid_q;
  assign bresp   = wbad_q ? SLVERR : OKAY;

  rstate_t           rs_q, rs_d;
  logic [IDSIZE-1:0] rid_q, rid_d;
  logic [ASIZE-1:0]  ridx_q, ridx_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic              rfix_q, rfix_d;
  logic              rbad_q, rbad_d;
  logic              rlast_q, rlast_d;
  logic [DSIZE-1:0]  rdata_q, rdata_d;

  // Next beat is fetched when the current one is accepted, so data is
  // registered and a same-cycle write is not yet visible.
  always_comb begin
    rs_d    = rs_q;
    rid_d   = rid_q;
    ridx_d  = ridx_q;
    rlen_d  = rlen_q;
    rcnt_d  = rcnt_q;
    rfix_d  = rfix_q;
    rbad_d  = rbad_q;
    rlast_d = rlast_q;
    rdata_d = rdata_q;
    unique case (rs_q)
      R_IDLE: begin
        if (arvalid) begin
          rid_d   = arid;
          ridx_d  = word_idx(araddr);
          rlen_d  = arlen;
          rcnt_d  = 8'd0;
          rfix_d  = (arburst == FIXED);
          rbad_d  = oob(araddr, arlen, arburst);
          rlast_d = (arlen == 8'd0);
          rdata_d = rbad_d ? '0 : mem[ridx_d[IW-1:0]];
          rs_d    = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rlast_d = 1'b0;
            rs_d    = R_IDLE;
          end else begin
            if (!rfix_q) ridx_d = ridx_q + 1'b1;
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = (rcnt_d == rlen_q);
            rdata_d = rbad_q ? '0 : mem[ridx_d[IW-1:0]];
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rs_q    <= R_IDLE;
      rid_q   <= '0;
      ridx_q  <= '0;
      rlen_q  <= '0;
      rcnt_q  <= '0;
      rfix_q  <= 1'b0;
      rbad_q  <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rs_q    <= rs_d;
      rid_q   <= rid_d;
      ridx_q  <= ridx_d;
      rlen_q  <= rlen_d;
      rcnt_q  <= rcnt_d;
      rfix_q  <= rfix_d;
      rbad_q  <= rbad_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
    end
  end

  assign arready = (rs_q == R_IDLE);
  assign rvalid  = (rs_q == R_DATA);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rlast   = rlast_q;
  assign rresp   = rbad_q ? SLVERR : OKAY;

`ifdef AXI4_RAM_RESPONDER_WSTRB_EN
  logic unused_ok;
  assign unused_ok = ^{awsize, arsize};
`else
  logic unused_ok;
  assign unused_ok = ^{awsize, arsize, wstrb};
`endif

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Bench for axi4_ram_responder: vector table plus scoreboarded read beats.
// Build with AXI4_RAM_RESPONDER_WSTRB_EN to exercise byte strobes.
module tb_axi4_ram_responder;

  logic        clock, rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  axi4_ram_responder dut (
    .clock(clock), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] dbase;
    int          nb;
    logic [1:0]  resp;
  } vec_t;

  rbeat_t      rq[$];
  logic [31:0] model[int];
  rbeat_t      mon_e;
  logic        held_v = 1'b0;
  logic [38:0] held;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  function automatic logic [31:0] mget(input int i);
    return model.exists(i) ? model[i] : 32'h0;
  endfunction

  function automatic bit m_bad(input logic [31:0] a, input logic [7:0] len,
                               input logic [1:0] burst);
    longint s;
    s = longint'(a) / 4;
    if (burst != 2'b00) s = s + len;
    return s >= 1024;
  endfunction

  always @(negedge clock) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && rvalid) chk("r_hold", {rid, rresp, rlast, rdata}, held);
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL r_extra: got beat %h, none expected", rdata);
        end else begin
          mon_e = rq.pop_front();
          chk("rdata", rdata, mon_e.data);
          chk("rresp", rresp, mon_e.resp);
          chk("rlast", rlast, mon_e.last);
          chk("rid", rid, mon_e.id);
        end
      end
      held_v = rvalid && !rready;
      held = {rid, rresp, rlast, rdata};
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
    @(negedge clock);
    while (!awready && n < 50) begin n++; @(negedge clock); end
    if (!awready) tmo("aw");
    @(posedge clock); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clock);
    while (!wready && n < 50) begin n++; @(negedge clock); end
    if (!wready) tmo("w");
    @(posedge clock); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    @(negedge clock);
    while (!bvalid && n < 50) begin n++; @(negedge clock); end
    if (!bvalid) tmo("b");
    else begin
      chk("bid", bid, id);
      chk("bresp", bresp, resp);
    end
    @(posedge clock); #1;
    bready = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
    @(negedge clock);
    while (!arready && n < 50) begin n++; @(negedge clock); end
    if (!arready) tmo("ar");
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain_r(input bit toggle);
    for (int c = 0; c < 2000; c++) begin
      rready = toggle ? (c % 3 == 0) : 1'b1;
      @(posedge clock); #1;
      if (rq.size() == 0) break;
    end
    rready = 1'b0;
    if (rq.size() != 0) begin
      tmo("r_drain");
      rq.delete();
    end
  endtask

  task automatic push_reads(input logic [3:0] id, input logic [31:0] a,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] resp);
    rbeat_t b;
    bit bad = m_bad(a, len, burst);
    int idx = int'(a / 4);
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id;
      b.data = bad ? 32'h0 : mget(idx);
      b.resp = resp;
      b.last = (i == int'(len));
      rq.push_back(b);
      if (burst != 2'b00) idx++;
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [31:0] base, input logic [3:0] s,
                    input int nb, input logic [1:0] resp);
    bit bad = m_bad(a, len, burst);
    int idx = int'(a / 4);
    logic [31:0] d, o;
    send_aw(id, a, len, burst);
    for (int i = 0; i < nb; i++) begin
      d = base + 32'(i);
      send_w(d, s, i == nb - 1);
      if (!bad) begin
`ifdef AXI4_RAM_RESPONDER_WSTRB_EN
        o = mget(idx);
        for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        model[idx] = o;
`else
        o = d;
        model[idx] = o;
`endif
      end
      if (burst != 2'b00) idx++;
    end
    get_b(id, resp);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [1:0] resp, input bit toggle);
    push_reads(id, a, len, burst, resp);
    send_ar(id, a, len, burst);
    drain_r(toggle);
    chk("arready_after_r", arready, 1'b1);
  endtask

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  32'h010, 8'd3,   2'b01, 32'hA0,       4,   2'b00};
    tbl[1]  = '{1'b0, 4'd5,  32'h010, 8'd3,   2'b01, 32'h0,        0,   2'b00};
    tbl[2]  = '{1'b1, 4'd1,  32'h040, 8'd2,   2'b00, 32'h1,        3,   2'b00};
    tbl[3]  = '{1'b0, 4'd2,  32'h040, 8'd0,   2'b01, 32'h0,        0,   2'b00};
    tbl[4]  = '{1'b1, 4'd4,  32'hFFC, 8'd0,   2'b01, 32'h5A5A0000, 1,   2'b00};
    tbl[5]  = '{1'b1, 4'd6,  32'hFFC, 8'd1,   2'b01, 32'hDEAD0000, 2,   2'b10};
    tbl[6]  = '{1'b0, 4'd7,  32'hFFC, 8'd1,   2'b01, 32'h0,        0,   2'b10};
    tbl[7]  = '{1'b0, 4'd8,  32'hFFC, 8'd0,   2'b01, 32'h0,        0,   2'b00};
    tbl[8]  = '{1'b1, 4'd9,  32'h100, 8'd7,   2'b10, 32'hB0,       8,   2'b00};
    tbl[9]  = '{1'b0, 4'd10, 32'h100, 8'd7,   2'b10, 32'h0,        0,   2'b00};
    tbl[10] = '{1'b1, 4'd11, 32'h500, 8'd3,   2'b01, 32'hC0,       2,   2'b00};
    tbl[11] = '{1'b0, 4'd12, 32'h500, 8'd1,   2'b01, 32'h0,        0,   2'b00};
    tbl[12] = '{1'b1, 4'd13, 32'h800, 8'd255, 2'b01, 32'h1000,     256, 2'b00};
    tbl[13] = '{1'b0, 4'd14, 32'h800, 8'd255, 2'b01, 32'h0,        0,   2'b00};
    tbl[14] = '{1'b0, 4'd15, 32'h040, 8'd2,   2'b00, 32'h0,        0,   2'b00};

    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd2;
    arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bid", bid, 4'd0);
    chk("rst_rid", rid, 4'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clock); #1;

    for (int v = 0; v < 15; v++) begin
      if (tbl[v].wr)
        wr(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].burst,
           tbl[v].dbase, 4'hF, tbl[v].nb, tbl[v].resp);
      else
        rd(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].burst,
           tbl[v].resp, 1'b0);
    end

    // rready stalls on an 8-beat read
    rd(4'd1, 32'h100, 8'd7, 2'b01, 2'b00, 1'b1);

    // W beat and AR to index 5 accepted on the same edge
    wr(4'd2, 32'h14, 8'd0, 2'b01, 32'h11, 4'hF, 1, 2'b00);
    send_aw(4'd2, 32'h14, 8'd0, 2'b01);
    push_reads(4'd3, 32'h14, 8'd0, 2'b01, 2'b00);
    wdata = 32'h22; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'd3; araddr = 32'h14; arlen = 8'd0; arburst = 2'b01;
    arvalid = 1'b1;
    @(negedge clock);
    chk("coinc_ready", {wready, arready}, 2'b11);
    @(posedge clock); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model[5] = 32'h22;
    get_b(4'd2, 2'b00);
    drain_r(1'b0);
    rd(4'd4, 32'h14, 8'd0, 2'b01, 2'b00, 1'b0);

    // reset in the middle of an 8-beat read
    push_reads(4'd9, 32'h100, 8'd7, 2'b01, 2'b00);
    send_ar(4'd9, 32'h100, 8'd7, 2'b01);
    rready = 1'b1;
    for (int c = 0; c < 50 && rq.size() > 6; c++) begin
      @(posedge clock); #1;
    end
    if (rq.size() > 6) tmo("mid_read");
    rst = 1'b1;
    rq.delete();
    rready = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_rvalid", rvalid, 1'b0);
    chk("post_rst_arready", arready, 1'b1);
    rd(4'd6, 32'h100, 8'd7, 2'b01, 2'b00, 1'b0);

    // byte strobes (ignored unless the strobe macro is defined)
    wr(4'd1, 32'h300, 8'd0, 2'b01, 32'h12345678, 4'hF, 1, 2'b00);
    wr(4'd2, 32'h300, 8'd0, 2'b01, 32'hFFFFFFFF, 4'h3, 1, 2'b00);
    rd(4'd3, 32'h300, 8'd0, 2'b01, 2'b00, 1'b0);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
